// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle MIPS control path: instruction fields,
// datapath mux encodings, ALU operations and the controller state set.
package cpu_defs_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_JR   = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_RS     = 2'd3;

   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   localparam logic [1:0] SRCB_RT   = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_BOFF = 2'd3;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT
   } state_t;

   function automatic logic r_alu_funct(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request goes unanswered; flags a timeout
// once MEM_WAIT_MAX such cycles have elapsed.
module mem_wait_timer #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic waiting,
   output logic timeout
);

   localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);

   logic [CW-1:0] count;

   // Any cycle without an outstanding unanswered request restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        count <= '0;
      else if (waiting) count <= count + 1'b1;
      else              count <= '0;
   end

   assign timeout = (count == CW'(MEM_WAIT_MAX));

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core: sequences the shared ALU,
// register file, IR/PC and the unified memory port.
module multicycle_controller #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned ALU_OP_W     = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_src,
   output logic                reg_we,
   output logic [1:0]          reg_dst,
   output logic [1:0]          wb_sel,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic                imm_zext,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                halted,
   output logic                illegal,
   output logic                bus_err
);
   import cpu_defs_pkg::*;

   state_t     state, next_state;
   logic       timeout, waiting;
   logic       set_illegal, set_bus_err;
   logic [2:0] aop;

   assign waiting = mem_req & ~mem_ready;
   assign alu_op  = ALU_OP_W'(aop);

   mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
      .clk     (clk),
      .reset   (reset),
      .waiting (waiting),
      .timeout (timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_FETCH;
         halted  <= 1'b0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state == S_HALT) halted  <= 1'b1;
         if (set_illegal)          illegal <= 1'b1;
         if (set_bus_err)          bus_err <= 1'b1;
      end
   end

   // Decode is gated by reset so an access in flight drops the instant reset rises.
   always_comb begin
      next_state  = state;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_ALU;
      reg_we      = 1'b0;
      reg_dst     = DST_RT;
      wb_sel      = WB_ALUOUT;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_RT;
      imm_zext    = 1'b0;
      aop         = ALU_ADD;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               alu_src_b = SRCB_FOUR;
               if (timeout) begin
                  next_state  = S_HALT;
                  set_bus_err = 1'b1;
               end else begin
                  mem_req = 1'b1;
                  if (mem_ready) begin
                     ir_we      = 1'b1;
                     pc_we      = 1'b1;
                     next_state = S_DECODE;
                  end
               end
            end
            S_DECODE: begin
               alu_src_b = SRCB_BOFF;
               case (opcode)
                  OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                  OP_BEQ, OP_BNE:   next_state = S_BRANCH;
                  OP_ADDI, OP_XORI: next_state = S_EXEC_I;
                  OP_J:             next_state = S_JUMP;
                  OP_JAL:           next_state = S_JAL;
                  OP_R: begin
                     if (funct == FN_JR)          next_state = S_JR;
                     else if (r_alu_funct(funct)) next_state = S_EXEC_R;
                     else begin
                        next_state  = S_HALT;
                        set_illegal = 1'b1;
                     end
                  end
                  default: begin
                     next_state  = S_HALT;
                     set_illegal = 1'b1;
                  end
               endcase
            end
            S_MEM_ADDR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRCB_IMM;
               next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
               iord = 1'b1;
               if (timeout) begin
                  next_state  = S_HALT;
                  set_bus_err = 1'b1;
               end else begin
                  mem_req = 1'b1;
                  mem_we  = (state == S_MEM_WR);
                  if (mem_ready) next_state = (state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
               end
            end
            S_MEM_WB: begin
               reg_we     = 1'b1;
               wb_sel     = WB_MDR;
               next_state = S_FETCH;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               if (funct == FN_SUB)      aop = ALU_SUB;
               else if (funct == FN_SLT) aop = ALU_SLT;
               next_state = S_WB_R;
            end
            S_WB_R: begin
               reg_we     = 1'b1;
               reg_dst    = DST_RD;
               next_state = S_FETCH;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               if (opcode == OP_XORI) begin
                  imm_zext = 1'b1;
                  aop      = ALU_XOR;
               end
               next_state = S_WB_I;
            end
            S_WB_I: begin
               reg_we     = 1'b1;
               next_state = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a = 1'b1;
               aop       = ALU_SUB;
               if (((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero)) begin
                  pc_we  = 1'b1;
                  pc_src = PC_ALUOUT;
               end
               next_state = S_FETCH;
            end
            S_JUMP: begin
               pc_we      = 1'b1;
               pc_src     = PC_JUMP;
               next_state = S_FETCH;
            end
            S_JAL: begin
               reg_we     = 1'b1;
               reg_dst    = DST_R31;
               wb_sel     = WB_PC;
               pc_we      = 1'b1;
               pc_src     = PC_JUMP;
               next_state = S_FETCH;
            end
            S_JR: begin
               pc_we      = 1'b1;
               pc_src     = PC_RS;
               next_state = S_FETCH;
            end
            default: ;
         endcase
      end
   end

endmodule
